psw_flag_ctrl: RTL and testbench
================================

PSW_FLAG_CTRL -- requirements
Module: psw_flag_ctrl

Interface
REQ-001 The module SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 The module SHALL have port clr_n, input, 1, asynchronous active-low reset.
REQ-003 The module SHALL have port req_valid, input, 1, request presented.
REQ-004 The module SHALL have port req_ready, output, 1, the block can accept a request.
REQ-005 The module SHALL have port req_op, input, 2, the operation: 00 FLAGS, 01 SET, 10 CLR, 11 TOGGLE.
REQ-006 The module SHALL have port alu_result, input, 16, the ALU result used by FLAGS.
REQ-007 The module SHALL have port alu_c and alu_v, input, 1 each, the ALU carry and overflow used by FLAGS.
REQ-008 The module SHALL have port flag_mask, input, 4, the NZVC bits FLAGS updates.
REQ-009 The module SHALL have port bit_mask, input, 16, the PSW bits SET/CLR/TOGGLE affect.
REQ-010 The module SHALL have port psw_q, input, 16, the current PSW register value.
REQ-011 The module SHALL have port psw_j and psw_k, output, 16 each, the J and K drives to the PSW JK-flip-flop bank.
REQ-012 The module SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-013 The module SHALL have port err, output, 1, a one-cycle mismatch pulse, coincident with done.

Function
REQ-014 Flag positions SHALL be C=bit0, V=bit1, Z=bit2, N=bit3; flag_mask[i] SHALL map to PSW bit i.
REQ-015 The FSM SHALL have the states IDLE, DRIVE and CHECK; req_ready SHALL be 1 only in IDLE.
REQ-016 A request SHALL be accepted when req_valid and req_ready are both 1 at a clock edge; all request inputs are registered at that edge.
REQ-017 On accept, the FSM SHALL go from IDLE to DRIVE; DRIVE lasts exactly 1 cycle and then goes to CHECK; CHECK lasts exactly 1 cycle and then goes to IDLE.
REQ-018 psw_j/psw_k SHALL be nonzero only in DRIVE; in all other states both are 16'h0000.
REQ-019 FLAGS: for each bit i<4 with flag_mask[i]=1, J[i]=f[i] and K[i]=~f[i], where f = {N=alu_result[15], Z=(alu_result==0), V=alu_v, C=alu_c}; all other bits SHALL have J=K=0.
REQ-020 SET SHALL drive J=bit_mask, K=0; CLR SHALL drive J=0, K=bit_mask; TOGGLE SHALL drive J=K=bit_mask.
REQ-021 J[i] and K[i] SHALL both be 1 only under TOGGLE.
REQ-022 In DRIVE the block SHALL register the expected value: (psw_q & ~m) | (new & m) for FLAGS/SET/CLR, and psw_q ^ bit_mask for TOGGLE.
REQ-023 In CHECK, done SHALL be 1, and err SHALL be 1 iff psw_q differs from the expected value.
REQ-024 Latency SHALL be: accept at edge N, J/K valid during cycle N+1, PSW updates at edge N+2, done in cycle N+2, next accept possible at edge N+3.
REQ-025 req_valid held high while req_ready=0 SHALL be ignored and not queued.
REQ-026 An all-zero mask SHALL still execute the full sequence, with J=K=0, done=1 and err=0.
REQ-027 Under FLAGS, bit_mask SHALL be ignored; under SET/CLR/TOGGLE, flag_mask and the ALU inputs SHALL be ignored.

Reset
REQ-028 While clr_n=0, the FSM SHALL be IDLE, req_ready=1, psw_j=psw_k=0, done=0, err=0, and the captured request and expected registers SHALL be 0.
REQ-029 Reset asserted in DRIVE or CHECK SHALL abort immediately: J/K return to 0 asynchronously and no done/err is produced.
REQ-030 After clr_n deasserts, the first accept SHALL be possible at the first clock edge.

Structure
REQ-031 The op encodings, the flag bit indices (C/V/Z/N) and the FSM state encoding SHALL live in a shared package, psw_pkg.
REQ-032 The J/K mask generation SHALL be the sub-module psw_jk_encode, purely combinational; the FSM, registers and check SHALL live in psw_flag_ctrl.
REQ-033 The bench SHALL connect psw_j/psw_k to the existing 16-bit PSW JK bank, with its active-high clr tied to ~clr_n and pre tied to 0, and psw_q fed back.

Verification
REQ-034 FLAGS with alu_result=16'h0000, c=1, v=0, mask=4'hF, PSW=0 -> DRIVE J=16'h0005, K=16'h000A; PSW=16'h0005; done=1, err=0.
REQ-035 FLAGS with alu_result=16'h8000, mask=4'b1000, PSW=16'h00F7 -> only bit3 is driven (J=16'h0008); PSW=16'h00FF.
REQ-036 SET bit_mask=16'hA000, then CLR 16'h2000, then TOGGLE 16'hFFFF from PSW=0 -> 16'hA000, 16'h8000, 16'h7FFF; each request has 3-cycle spacing.
REQ-037 req_valid held high for 6 cycles -> exactly 2 accepts; req_ready pattern 1,0,0,1,0,0.
REQ-038 PSW bank pre forced to 1 during a CLR 16'h0001 -> err=1 with done in cycle N+2.
REQ-039 clr_n pulsed low in DRIVE -> J=K=0 immediately; no done; IDLE with req_ready=1 after release.

Source files
------------

// File: rtl/psw_pkg.sv
// Shared definitions for the PSW flag controller: op codes, flag positions,
// FSM state encoding and the ALU flag extraction helper.
package psw_pkg;

  localparam int DATA_W = 16;
  localparam int NFLAGS = 4;

  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  typedef enum logic [1:0] {
    OP_FLAGS  = 2'b00,
    OP_SET    = 2'b01,
    OP_CLR    = 2'b10,
    OP_TOGGLE = 2'b11
  } psw_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_CHECK = 2'b10
  } psw_state_e;

  function automatic logic [NFLAGS-1:0] alu_flags(input logic [DATA_W-1:0] res,
                                                  input logic c,
                                                  input logic v);
    logic [NFLAGS-1:0] f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    f[FLAG_Z] = (res == '0);
    f[FLAG_N] = res[DATA_W-1];
    return f;
  endfunction

endpackage

// File: rtl/psw_jk_encode.sv
// Combinational J/K mask generator for one PSW update request.
// J=K=1 on a bit only arises from TOGGLE.
module psw_jk_encode
  import psw_pkg::*;
(
  input  psw_op_e             op,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic                alu_c,
  input  logic                alu_v,
  input  logic [NFLAGS-1:0]   flag_mask,
  input  logic [DATA_W-1:0]   bit_mask,
  output logic [DATA_W-1:0]   j,
  output logic [DATA_W-1:0]   k
);

  logic [NFLAGS-1:0] f;

  always_comb begin
    j = '0;
    k = '0;
    f = alu_flags(alu_result, alu_c, alu_v);
    case (op)
      OP_FLAGS: begin
        j[NFLAGS-1:0] = f & flag_mask;
        k[NFLAGS-1:0] = ~f & flag_mask;
      end
      OP_SET:    j = bit_mask;
      OP_CLR:    k = bit_mask;
      OP_TOGGLE: begin
        j = bit_mask;
        k = bit_mask;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/psw_flag_ctrl.sv
// PSW flag controller: captures a request, drives the JK bank for one cycle,
// then checks the PSW read-back against the expected value.
module psw_flag_ctrl
  import psw_pkg::*;
(
  input  logic              clk,
  input  logic              clr_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_c,
  input  logic              alu_v,
  input  logic [NFLAGS-1:0] flag_mask,
  input  logic [DATA_W-1:0] bit_mask,
  input  logic [DATA_W-1:0] psw_q,
  output logic [DATA_W-1:0] psw_j,
  output logic [DATA_W-1:0] psw_k,
  output logic              done,
  output logic              err
);

  psw_state_e        state;
  psw_op_e           op_p1;
  logic [DATA_W-1:0] res_p1;
  logic              c_p1;
  logic              v_p1;
  logic [NFLAGS-1:0] fm_p1;
  logic [DATA_W-1:0] bm_p1;
  logic [DATA_W-1:0] exp_p2;
  logic [DATA_W-1:0] enc_j;
  logic [DATA_W-1:0] enc_k;
  logic [DATA_W-1:0] exp_next;

  psw_jk_encode u_enc (
    .op         (op_p1),
    .alu_result (res_p1),
    .alu_c      (c_p1),
    .alu_v      (v_p1),
    .flag_mask  (fm_p1),
    .bit_mask   (bm_p1),
    .j          (enc_j),
    .k          (enc_k)
  );

  // j|k is exactly the set of bits the op touches, and j carries their new value
  always_comb begin
    exp_next = (psw_q & ~(enc_j | enc_k)) | enc_j;
    if (op_p1 == OP_TOGGLE)
      exp_next = psw_q ^ enc_j;
  end

  // p1: request capture (IDLE -> DRIVE), p2: expected value (DRIVE -> CHECK)
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state  <= ST_IDLE;
      op_p1  <= OP_FLAGS;
      res_p1 <= '0;
      c_p1   <= 1'b0;
      v_p1   <= 1'b0;
      fm_p1  <= '0;
      bm_p1  <= '0;
      exp_p2 <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_p1  <= psw_op_e'(req_op);
            res_p1 <= alu_result;
            c_p1   <= alu_c;
            v_p1   <= alu_v;
            fm_p1  <= flag_mask;
            bm_p1  <= bit_mask;
            state  <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          exp_p2 <= exp_next;
          state  <= ST_CHECK;
        end
        ST_CHECK: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (state == ST_IDLE);
  assign psw_j     = (state == ST_DRIVE) ? enc_j : '0;
  assign psw_k     = (state == ST_DRIVE) ? enc_k : '0;
  assign done      = (state == ST_CHECK);
  assign err       = done && (psw_q != exp_p2);

endmodule

// File: tb/tb_psw_flag_ctrl.sv
// Bench for psw_flag_ctrl with a behavioural JK PSW bank and a request-level model.
module tb_psw_flag_ctrl;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [15:0] alu_result = '0;
  logic        alu_c = 1'b0;
  logic        alu_v = 1'b0;
  logic [3:0]  flag_mask = '0;
  logic [15:0] bit_mask = '0;
  logic [15:0] psw_q = '0;
  logic [15:0] psw_j;
  logic [15:0] psw_k;
  logic        done;
  logic        err;
  logic        bank_pre = 1'b0;
  logic        bank_clr;

  int n_checks = 0;
  int n_err = 0;

  psw_flag_ctrl dut (
    .clk(clk), .clr_n(clr_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .alu_result(alu_result), .alu_c(alu_c), .alu_v(alu_v),
    .flag_mask(flag_mask), .bit_mask(bit_mask), .psw_q(psw_q),
    .psw_j(psw_j), .psw_k(psw_k), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // PSW JK bank: async clr dominates, then async pre, else JK update on clk
  assign bank_clr = ~clr_n;
  always @(posedge clk or posedge bank_clr or posedge bank_pre) begin
    if (bank_clr)      psw_q <= '0;
    else if (bank_pre) psw_q <= 16'hFFFF;
    else               psw_q <= (psw_j & ~psw_q) | (~psw_k & psw_q);
  end

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Model: result of a request on the PSW, straight from the operation rules
  function automatic logic [15:0] apply_op(input logic [1:0] op, input logic [15:0] psw,
      input logic [15:0] res, input logic c, input logic v,
      input logic [3:0] fm, input logic [15:0] bm);
    logic [15:0] r;
    r = psw;
    case (op)
      2'b00: begin
        if (fm[0]) r[0] = c;
        if (fm[1]) r[1] = v;
        if (fm[2]) r[2] = (res == 16'h0000);
        if (fm[3]) r[3] = res[15];
      end
      2'b01: r = psw | bm;
      2'b10: r = psw & ~bm;
      default: r = psw ^ bm;
    endcase
    return r;
  endfunction

  task automatic model_jk(input logic [1:0] op, input logic [15:0] res, input logic c,
      input logic v, input logic [3:0] fm, input logic [15:0] bm,
      output logic [15:0] j, output logic [15:0] k);
    logic [3:0] f;
    f = {res[15], res == 16'h0000, v, c};
    j = '0;
    k = '0;
    case (op)
      2'b00: for (int i = 0; i < 4; i++) begin
        if (fm[i]) begin
          j[i] = f[i];
          k[i] = ~f[i];
        end
      end
      2'b01: j = bm;
      2'b10: k = bm;
      default: begin j = bm; k = bm; end
    endcase
  endtask

  // m_slot: cycles elapsed since the accept (0 = not busy)
  int          m_slot = 0;
  logic [15:0] m_psw = '0;
  logic [15:0] m_j = '0, m_k = '0, m_exp = '0;
  logic        m_err = 1'b0;
  logic [1:0]  m_op = '0;
  logic [15:0] m_res = '0, m_bm = '0;
  logic        m_c = 1'b0, m_v = 1'b0;
  logic [3:0]  m_fm = '0;

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_slot = 0; m_psw = '0; m_j = '0; m_k = '0; m_err = 1'b0;
    end else begin
      if (bank_pre) m_psw = 16'hFFFF;
      if (m_slot == 0) begin
        if (req_valid) begin
          m_op = req_op; m_res = alu_result; m_c = alu_c; m_v = alu_v;
          m_fm = flag_mask; m_bm = bit_mask;
          model_jk(m_op, m_res, m_c, m_v, m_fm, m_bm, m_j, m_k);
          m_slot = 1;
        end
      end else if (m_slot == 1) begin
        m_exp = apply_op(m_op, m_psw, m_res, m_c, m_v, m_fm, m_bm);
        m_psw = bank_pre ? 16'hFFFF : m_exp;
        m_err = (m_psw != m_exp);
        m_slot = 2;
      end else begin
        m_slot = 0;
      end
    end
  end

  always @(negedge clk) begin
    #1;
    chk("ready", {15'b0, req_ready}, {15'b0, m_slot == 0});
    chk("psw_j", psw_j, (m_slot == 1) ? m_j : 16'h0000);
    chk("psw_k", psw_k, (m_slot == 1) ? m_k : 16'h0000);
    chk("done", {15'b0, done}, {15'b0, m_slot == 2});
    chk("err", {15'b0, err}, {15'b0, (m_slot == 2) && m_err});
    chk("psw_q", psw_q, bank_pre ? 16'hFFFF : m_psw);
  end

  task automatic present(input logic [1:0] op, input logic [15:0] res, input logic c,
      input logic v, input logic [3:0] fm, input logic [15:0] bm);
    req_op = op; alu_result = res; alu_c = c; alu_v = v; flag_mask = fm; bit_mask = bm;
    req_valid = 1'b1;
  endtask

  // Called at an IDLE negedge; returns J/K seen in DRIVE and PSW/done/err seen in CHECK
  task automatic run(input logic [1:0] op, input logic [15:0] res, input logic c,
      input logic v, input logic [3:0] fm, input logic [15:0] bm,
      output logic [15:0] dj, output logic [15:0] dk, output logic [15:0] pq,
      output logic d, output logic e);
    present(op, res, c, v, fm, bm);
    @(negedge clk);
    req_valid = 1'b0;
    dj = psw_j; dk = psw_k;
    @(negedge clk);
    pq = psw_q; d = done; e = err;
    @(negedge clk);
  endtask

  logic [15:0] dj, dk, pq;
  logic        d, e;
  int          acc;
  logic [5:0]  ready_pat;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", {15'b0, req_ready}, 16'h0001);
    chk("rst_j", psw_j, 16'h0000);
    clr_n = 1'b1;

    run(2'b00, 16'h0000, 1'b1, 1'b0, 4'hF, 16'h0000, dj, dk, pq, d, e);
    chk("flags0_j", dj, 16'h0005);
    chk("flags0_k", dk, 16'h000A);
    chk("flags0_psw", pq, 16'h0005);
    chk("flags0_done", {15'b0, d}, 16'h0001);
    chk("flags0_err", {15'b0, e}, 16'h0000);

    run(2'b01, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h00F7, dj, dk, pq, d, e);
    chk("pre_f7", pq, 16'h00F7);
    run(2'b00, 16'h8000, 1'b0, 1'b0, 4'b1000, 16'h0000, dj, dk, pq, d, e);
    chk("flagsN_j", dj, 16'h0008);
    chk("flagsN_k", dk, 16'h0000);
    chk("flagsN_psw", pq, 16'h00FF);

    run(2'b10, 16'h0000, 1'b0, 1'b0, 4'h0, 16'hFFFF, dj, dk, pq, d, e);
    chk("clr_all", pq, 16'h0000);
    run(2'b01, 16'h0000, 1'b0, 1'b0, 4'h0, 16'hA000, dj, dk, pq, d, e);
    chk("set_a000", pq, 16'hA000);
    run(2'b10, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h2000, dj, dk, pq, d, e);
    chk("clr_2000", pq, 16'h8000);
    run(2'b11, 16'h0000, 1'b0, 1'b0, 4'h0, 16'hFFFF, dj, dk, pq, d, e);
    chk("tog_ffff_j", dj, 16'hFFFF);
    chk("tog_ffff_k", dk, 16'hFFFF);
    chk("tog_ffff", pq, 16'h7FFF);

    // Zero flag mask: bit_mask must be ignored and nothing driven
    run(2'b00, 16'h0000, 1'b1, 1'b1, 4'h0, 16'hFFFF, dj, dk, pq, d, e);
    chk("zmask_j", dj, 16'h0000);
    chk("zmask_k", dk, 16'h0000);
    chk("zmask_done", {15'b0, d}, 16'h0001);
    chk("zmask_psw", pq, 16'h7FFF);

    run(2'b00, 16'h1234, 1'b0, 1'b1, 4'hF, 16'h0000, dj, dk, pq, d, e);
    chk("flags_v", pq, 16'h7FF2);
    run(2'b00, 16'hFFFF, 1'b1, 1'b0, 4'b0101, 16'h0000, dj, dk, pq, d, e);
    chk("flags_cz", pq, 16'h7FF3);
    run(2'b01, 16'h0000, 1'b1, 1'b1, 4'hF, 16'h8000, dj, dk, pq, d, e);
    chk("set_ign_alu", pq, 16'hFFF3);

    // valid held for 6 cycles
    ready_pat = 6'b001001;
    acc = 0;
    present(2'b01, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      chk("ready_pat", {15'b0, req_ready}, {15'b0, ready_pat[i]});
      if (req_ready && req_valid) acc++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("accepts", acc[15:0], 16'd2);

    // Forced preset during CLR of bit0 must be flagged
    bank_pre = 1'b1;
    present(2'b10, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h0001);
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre_k", psw_k, 16'h0001);
    @(negedge clk);
    chk("pre_done", {15'b0, done}, 16'h0001);
    chk("pre_err", {15'b0, err}, 16'h0001);
    bank_pre = 1'b0;
    @(negedge clk);

    // Reset pulse during DRIVE
    present(2'b01, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h000F);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_j_before", psw_j, 16'h000F);
    #2 clr_n = 1'b0;
    #1;
    chk("abort_j", psw_j, 16'h0000);
    chk("abort_k", psw_k, 16'h0000);
    chk("abort_ready", {15'b0, req_ready}, 16'h0001);
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    chk("abort_nodone", {15'b0, done}, 16'h0000);
    chk("abort_psw", psw_q, 16'h0000);

    run(2'b01, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h0003, dj, dk, pq, d, e);
    chk("post_reset", pq, 16'h0003);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
